// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution output path.
package conv_pkg;

    localparam int unsigned CONV_NUM_DFLT = 4;
    localparam int unsigned ADDR_W_DFLT   = 10;
    localparam int unsigned DATA_W_DFLT   = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StCap,
        StSend
    } drain_state_e;

    // Filter-index width; a single lane still needs one bit.
    function automatic int unsigned fi_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofm_lane_serializer.sv
// Captures all OFM lanes for one address and shifts them out one byte per valid/ready beat.
module ofm_lane_serializer
    import conv_pkg::*;
#(
    parameter int unsigned CONV_NUM = CONV_NUM_DFLT,
    parameter int unsigned DATA_W   = DATA_W_DFLT,
    parameter int unsigned FI_W     = fi_width(CONV_NUM)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load,
    input  logic [CONV_NUM*DATA_W-1:0]   i_word,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [DATA_W-1:0]            o_data,
    output logic [FI_W-1:0]              o_lane,
    output logic                         o_last_lane,
    output logic                         o_hs
);

    localparam logic [FI_W-1:0] LastLane = FI_W'(CONV_NUM - 1);

    logic [CONV_NUM*DATA_W-1:0] r_word;
    logic [FI_W-1:0]            r_lane;
    logic                       r_valid;
    logic                       w_last_lane;
    logic                       w_hs;

    assign w_last_lane = (r_lane == LastLane);
    assign w_hs        = r_valid & i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word  <= '0;
            r_lane  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_lane  <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            if (w_last_lane) begin
                r_valid <= 1'b0;
            end else begin
                r_lane <= r_lane + FI_W'(1);
                r_word <= r_word >> DATA_W;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_word[DATA_W-1:0];
    assign o_lane      = r_lane;
    assign o_last_lane = w_last_lane;
    assign o_hs        = w_hs;

endmodule

// File: rtl/ofm_stream_out.sv
// Drains every OFM word after conv completion and streams lanes out address-major with
// filter/address sideband.
module ofm_stream_out
    import conv_pkg::*;
#(
    parameter int unsigned CONV_NUM  = CONV_NUM_DFLT,
    parameter int unsigned ADDR_W    = ADDR_W_DFLT,
    parameter int unsigned DATA_W    = DATA_W_DFLT,
    parameter int unsigned OFM_DEPTH = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_done,
    output logic [CONV_NUM*ADDR_W-1:0]    o_ofm_addr,
    input  logic [CONV_NUM*DATA_W-1:0]    i_ofm_out,
    output logic [DATA_W-1:0]             o_out_data,
    output logic [fi_width(CONV_NUM)-1:0] o_out_filt,
    output logic [ADDR_W-1:0]             o_out_addr,
    output logic                          o_out_last,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_busy,
    output logic                          o_drained
);

    localparam int unsigned       FI_W     = fi_width(CONV_NUM);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(OFM_DEPTH - 1);

    drain_state_e      r_state, w_state_d;
    logic              r_done_q;
    logic [ADDR_W-1:0] r_addr_cnt, w_addr_d;
    logic [ADDR_W-1:0] r_ofm_addr, w_ofm_addr_d;
    logic              r_busy, w_busy_d;
    logic              r_drained, w_drained_d;
    logic              w_start;
    logic              w_load;
    logic              w_valid;
    logic              w_hs;
    logic              w_last_lane;
    logic [FI_W-1:0]   w_lane;

    assign w_start = i_done & ~r_done_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_done_q   <= 1'b0;
            r_addr_cnt <= '0;
            r_ofm_addr <= '0;
            r_busy     <= 1'b0;
            r_drained  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_done_q   <= i_done;
            r_addr_cnt <= w_addr_d;
            r_ofm_addr <= w_ofm_addr_d;
            r_busy     <= w_busy_d;
            r_drained  <= w_drained_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_addr_d     = r_addr_cnt;
        w_ofm_addr_d = r_ofm_addr;
        w_busy_d     = r_busy;
        w_drained_d  = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StAddr;
                    w_addr_d  = '0;
                    w_busy_d  = 1'b1;
                end
            end
            StAddr: begin
                w_ofm_addr_d = r_addr_cnt;
                w_state_d    = StWait;
            end
            // One cycle covers both async and single-cycle synchronous read latency.
            StWait: w_state_d = StCap;
            StCap: begin
                w_load    = 1'b1;
                w_state_d = StSend;
            end
            StSend: begin
                if (w_hs && w_last_lane) begin
                    if (r_addr_cnt != LastAddr) begin
                        w_addr_d  = r_addr_cnt + ADDR_W'(1);
                        w_state_d = StAddr;
                    end else begin
                        w_busy_d    = 1'b0;
                        w_drained_d = 1'b1;
                        w_state_d   = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    ofm_lane_serializer #(
        .CONV_NUM (CONV_NUM),
        .DATA_W   (DATA_W),
        .FI_W     (FI_W)
    ) u_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_word      (i_ofm_out),
        .i_ready     (i_out_ready),
        .o_valid     (w_valid),
        .o_data      (o_out_data),
        .o_lane      (w_lane),
        .o_last_lane (w_last_lane),
        .o_hs        (w_hs)
    );

    // The read address is left in place after a drain; the top level may still probe it.
    assign o_ofm_addr  = {CONV_NUM{r_ofm_addr}};
    assign o_out_filt  = w_lane;
    assign o_out_addr  = r_addr_cnt;
    assign o_out_last  = w_valid & w_last_lane & (r_addr_cnt == LastAddr);
    assign o_out_valid = w_valid;
    assign o_busy      = r_busy;
    assign o_drained   = r_drained;

endmodule

// File: tb/tb_ofm_stream_out.sv
// Scoreboard bench: expected beats queued at each start, monitor pops on every handshake.
module tb_ofm_stream_out;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] filt;
        logic [9:0] addr;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst, done0, done1, ready;
    logic sel, mon_en, rand_ready;

    logic [39:0] ofm_addr0;
    logic [31:0] ofm_out0;
    logic [7:0]  data0;
    logic [1:0]  filt0;
    logic [9:0]  oaddr0;
    logic        last0, valid0, busy0, drained0;

    logic [9:0]  ofm_addr1;
    logic [7:0]  ofm_out1;
    logic [7:0]  data1;
    logic [0:0]  filt1;
    logic [9:0]  oaddr1;
    logic        last1, valid1, busy1, drained1;

    logic [7:0] mem0 [4][4];
    logic [7:0] mem1;

    logic       m_valid, m_last, m_busy, m_drained;
    logic [7:0] m_data;
    logic [1:0] m_filt;
    logic [9:0] m_oaddr;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    hs_cnt = 0;
    logic  prev_valid, prev_ready, prev_final;
    beat_t prev_beat, act_beat, exp_beat;

    always #5 clk = ~clk;

    ofm_stream_out #(
        .CONV_NUM  (4),
        .ADDR_W    (10),
        .DATA_W    (8),
        .OFM_DEPTH (4)
    ) dut0 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_done      (done0),
        .o_ofm_addr  (ofm_addr0),
        .i_ofm_out   (ofm_out0),
        .o_out_data  (data0),
        .o_out_filt  (filt0),
        .o_out_addr  (oaddr0),
        .o_out_last  (last0),
        .o_out_valid (valid0),
        .i_out_ready (ready),
        .o_busy      (busy0),
        .o_drained   (drained0)
    );

    ofm_stream_out #(
        .CONV_NUM  (1),
        .ADDR_W    (10),
        .DATA_W    (8),
        .OFM_DEPTH (1)
    ) dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_done      (done1),
        .o_ofm_addr  (ofm_addr1),
        .i_ofm_out   (ofm_out1),
        .o_out_data  (data1),
        .o_out_filt  (filt1),
        .o_out_addr  (oaddr1),
        .o_out_last  (last1),
        .o_out_valid (valid1),
        .i_out_ready (ready),
        .o_busy      (busy1),
        .o_drained   (drained1)
    );

    // Asynchronous-read OFM memories.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ofm_out0[k*8 +: 8] = mem0[k][ofm_addr0[k*10 +: 2]];
        end
        ofm_out1 = mem1;
    end

    always_comb begin
        m_valid   = sel ? valid1 : valid0;
        m_data    = sel ? data1 : data0;
        m_filt    = sel ? {1'b0, filt1} : filt0;
        m_oaddr   = sel ? oaddr1 : oaddr0;
        m_last    = sel ? last1 : last0;
        m_busy    = sel ? busy1 : busy0;
        m_drained = sel ? drained1 : drained0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        act_beat = {m_data, m_filt, m_oaddr, m_last};
        if (rst || !mon_en) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (m_drained || prev_final) check("drained_pulse", m_drained, prev_final);
            if (prev_valid && !prev_ready) begin
                check("stall_valid_held", m_valid, 1);
                check("stall_payload_stable", act_beat, prev_beat);
            end
            if (m_valid) check("busy_with_valid", m_busy, 1);
            prev_final = 1'b0;
            if (m_valid && ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", act_beat, 0);
                    if (act_beat == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat actual=extra required=none");
                    end
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat_payload", act_beat, exp_beat);
                    prev_final = exp_beat.last;
                    hs_cnt++;
                end
            end
            prev_valid = m_valid;
            prev_ready = ready;
            prev_beat  = act_beat;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain order: every address, and within it every filter lane.
    task automatic push_model(input bit which);
        beat_t b;
        if (!which) begin
            for (int a = 0; a < 4; a++) begin
                for (int k = 0; k < 4; k++) begin
                    b.data = mem0[k][a];
                    b.filt = 2'(k);
                    b.addr = 10'(a);
                    b.last = (a == 3) && (k == 3);
                    sb.push_back(b);
                end
            end
        end else begin
            b.data = mem1;
            b.filt = 2'd0;
            b.addr = 10'd0;
            b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    task automatic start_drain(input bit which);
        int n;
        push_model(which);
        if (which) done1 = 1'b1;
        else       done0 = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_valid && n < 20);
        check("first_valid_latency", n, 4);
    endtask

    task automatic wait_drained(input bit chk_busy);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            tick();
            n++;
            if (m_drained) seen = 1'b1;
            else if (chk_busy) check("busy_continuous", m_busy, 1);
        end
        check("drained_seen", seen, 1);
        check("queue_empty", sb.size(), 0);
        check("busy_after_drain", m_busy, 0);
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (hs_cnt < n && t < 2000) begin
            tick();
            t++;
        end
        check("beat_count_reached", hs_cnt >= n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        done0 = 1'b0;
        done1 = 1'b0;
        ready = 1'b1;
        sel = 1'b0;
        mon_en = 1'b1;
        rand_ready = 1'b0;
        mem1 = 8'hA5;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 4; a++) mem0[k][a] = 8'(16 * k + a);

        repeat (3) tick();
        check("rst_valid", valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ofm_addr", ofm_addr0, 0);
        check("rst_last", last0, 0);
        check("rst_drained", drained0, 0);
        check("rst_payload", {data0, filt0, oaddr0}, 0);
        check("rst_valid_single", valid1, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic in-order drain, ready always high.
        start_drain(0);
        wait_drained(1);
        check("ofm_addr_holds", ofm_addr0, {4{10'd3}});
        done0 = 1'b0;
        tick();

        // Random backpressure, fixed then random memory contents.
        rand_ready = 1'b1;
        start_drain(0);
        wait_drained(1);
        done0 = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 4; a++) mem0[k][a] = 8'($urandom);
        tick();
        start_drain(0);
        wait_drained(1);
        rand_ready = 1'b0;
        ready = 1'b1;
        done0 = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 4; a++) mem0[k][a] = 8'(16 * k + a);
        tick();

        // done held high after the drain must not restart it.
        start_drain(0);
        wait_drained(1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("held_done_no_restart", {busy0, valid0}, 0);
        end
        done0 = 1'b0;
        tick();
        start_drain(0);
        wait_drained(1);
        done0 = 1'b0;
        tick();

        // Second done edge mid-drain is ignored.
        base = hs_cnt;
        start_drain(0);
        wait_beats(base + 5);
        done0 = 1'b0;
        tick();
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        wait_drained(1);
        repeat (10) tick();
        check("no_extra_drain", {busy0, valid0}, 0);

        // Reset while beat 7 is stalled.
        base = hs_cnt;
        start_drain(0);
        wait_beats(base + 6);
        ready = 1'b0;
        repeat (2) tick();
        check("beat7_stalled_valid", valid0, 1);
        check("beat7_stalled_addr", {oaddr0, filt0}, {10'd1, 2'd2});
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", valid0, 0);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_drained", drained0, 0);
        sb.delete();
        done0 = 1'b0;
        tick();
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_drained_after_rst", drained0, 0);
        end
        check("ofm_addr_after_rst", ofm_addr0, 0);
        start_drain(0);
        wait_drained(1);
        done0 = 1'b0;

        // Single-lane, single-address instance.
        mon_en = 1'b0;
        sel = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        start_drain(1);
        wait_drained(1);
        check("single_ofm_addr", ofm_addr1, 0);
        done1 = 1'b0;
        repeat (5) tick();
        check("single_no_extra", {busy1, valid1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
